fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage for the MIPS datapath. Owns the program counter,
//  drives the word address into the combinational instruction memory and
//  captures the returned word into the IF/ID pipeline register.
//  Handles start/halt sequencing, stalls and branch/jump redirects from the
//  decode stage.
// PARAMETERS
//  ADDR_W   8   instruction-memory word-address width (PC width)
//  DATA_W   32  instruction width
//  RESET_PC 0   PC value loaded on reset
// PORTS
//  clk            in  1       rising-edge clock
//  rst_n          in  1       asynchronous active-low reset
//  start          in  1       one-cycle pulse, IDLE->RUN
//  halt           in  1       level, RUN->HALT
//  stall          in  1       hold PC and IF/ID (decode hazard)
//  branch_taken   in  1       redirect to branch target
//  branch_offset  in  16      signed word offset, relative to if_id_pc_plus1
//  jump           in  1       redirect to jump target
//  jump_target    in  26      J-type target field; bits [ADDR_W-1:0] used
//  instr_rd       in  DATA_W  instruction word from memory for address pc
//  pc             out ADDR_W  current fetch address to instruction memory
//  if_id_instr    out DATA_W  registered instruction for decode
//  if_id_pc_plus1 out ADDR_W  registered pc+1 of that instruction
//  if_id_valid    out 1       if_id_instr is a real, in-path instruction
//  running        out 1       1 while state==RUN
//  fetch_count    out 16      saturating count of valid instructions captured
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, if_id_instr=0,
//    if_id_pc_plus1=0, if_id_valid=0, running=0, fetch_count=0.
//  - FSM: IDLE --start--> RUN --halt--> HALT. HALT is terminal until reset.
//    halt has priority over start. In IDLE/HALT, pc holds and if_id_valid=0.
//  - RUN, per rising edge, priority order:
//    1 branch_taken: pc <= if_id_pc_plus1 + branch_offset[ADDR_W-1:0] (mod 2^ADDR_W)
//    2 jump:         pc <= jump_target[ADDR_W-1:0]
//    3 stall:        pc, if_id_* and fetch_count hold
//    4 else:         pc <= pc+1 (255 wraps to 0); if_id_instr <= instr_rd;
//                    if_id_pc_plus1 <= pc+1; if_id_valid <= 1; fetch_count++
//  - Redirect (1 or 2) squashes the wrong-path fetch: if_id_instr <= 0 (nop),
//    if_id_valid <= 0, fetch_count unchanged. Redirect overrides stall.
//  - Latency: instruction at address A appears on if_id_instr one clock after
//    pc==A. First valid IF/ID is one clock after the start edge.
//  - halt asserted the same cycle as a redirect: enter HALT, pc holds, no redirect.
//  - fetch_count saturates at 16'hFFFF.
//  - Reset mid-RUN returns immediately to the reset values; start is required again.
// TESTING
//  1 Reset then idle 5 cycles -> pc=0, if_id_valid=0, running=0, fetch_count=0.
//  2 start, with memory holding 0x20010003 @0 and 0x20020009 @1:
//    next edges -> if_id_instr=0x20010003, pc_plus1=1; then 0x20020009, pc_plus1=2.
//  3 stall for 3 cycles at pc=3 -> pc stays 3, IF/ID frozen, fetch_count frozen;
//    on release -> pc=4.
//  4 branch_taken, offset=16'hFFFE, if_id_pc_plus1=5 -> pc=3, if_id_valid=0 for
//    one cycle, if_id_instr=0.
//  5 jump, target=26'h0000006, with stall=1 -> pc=6 (redirect beats stall).
//    Also pc=255 with no redirect -> pc=0.
//  6 halt in RUN -> running=0, pc frozen, start ignored.
//    rst_n pulse low mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: control from the pipeline, redirect requests from decode,
// the instruction-memory read path and the IF/ID register outputs.
interface fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic              halt;
    logic              stall;
    logic              branch_taken;
    logic [15:0]       branch_offset;
    logic              jump;
    logic [25:0]       jump_target;
    logic [DATA_W-1:0] instr_rd;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] if_id_instr;
    logic [ADDR_W-1:0] if_id_pc_plus1;
    logic              if_id_valid;
    logic              running;
    logic [15:0]       fetch_count;

    // Fetch-stage side
    modport master (
        input  start, halt, stall, branch_taken, branch_offset,
               jump, jump_target, instr_rd,
        output pc, if_id_instr, if_id_pc_plus1, if_id_valid,
               running, fetch_count
    );

    // Pipeline / memory side
    modport slave (
        output start, halt, stall, branch_taken, branch_offset,
               jump, jump_target, instr_rd,
        input  pc, if_id_instr, if_id_pc_plus1, if_id_valid,
               running, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and fills the IF/ID register. Sequences IDLE/RUN/HALT,
// honours decode stalls and applies branch/jump redirects (squashing the
// wrong-path fetch).
module fetch_stage #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [1:0]         state;
    logic [ADDR_W-1:0]  pc_p0;
    logic [DATA_W-1:0]  instr_p1;
    logic [ADDR_W-1:0]  pc_plus1_p1;
    logic               vld_p1;
    logic [15:0]        fetch_cnt;

    logic signed [15:0] br_off;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  br_tgt;
    logic [ADDR_W-1:0]  jmp_tgt;
    logic               run_go;
    logic               redirect;
    logic               advance;
    logic               unused_hi_bits;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-PC candidates and the per-cycle action decode (halt beats redirect, redirect beats stall)
    always_comb begin
        br_off   = $signed(bus.branch_offset);
        pc_inc   = pc_p0 + {{(ADDR_W-1){1'b0}}, 1'b1};
        br_tgt   = pc_plus1_p1 + br_off[ADDR_W-1:0];
        jmp_tgt  = bus.jump_target[ADDR_W-1:0];
        run_go   = (state == ST_RUN) && !bus.halt;
        redirect = run_go && (bus.branch_taken || bus.jump);
        advance  = run_go && !redirect && !bus.stall;
    end

    // Only the low ADDR_W bits of the offset/target reach the PC
    assign unused_hi_bits = ^{bus.jump_target[25:ADDR_W], br_off[15:ADDR_W]};

    // Run-control FSM: IDLE -> RUN on start, RUN -> HALT on halt, HALT sticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.start && !bus.halt) state <= ST_RUN;
                ST_RUN:  if (bus.halt)               state <= ST_HALT;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p0: program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p0 <= RESET_PC;
        end else if (redirect) begin
            pc_p0 <= bus.branch_taken ? br_tgt : jmp_tgt;
        end else if (advance) begin
            pc_p0 <= pc_inc;
        end
    end

    // Stage p1: IF/ID register; a redirect turns the wrong-path slot into a nop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p1    <= '0;
            pc_plus1_p1 <= '0;
            vld_p1      <= 1'b0;
        end else if (redirect) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
        end else if (advance) begin
            instr_p1    <= bus.instr_rd;
            pc_plus1_p1 <= pc_inc;
            vld_p1      <= 1'b1;
        end else if (!run_go) begin
            vld_p1 <= 1'b0;
        end
    end

    // Saturating count of valid instructions captured into IF/ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
        end else if (advance) begin
            fetch_cnt <= sat_inc16(fetch_cnt);
        end
    end

    assign bus.pc             = pc_p0;
    assign bus.if_id_instr    = instr_p1;
    assign bus.if_id_pc_plus1 = pc_plus1_p1;
    assign bus.if_id_valid    = vld_p1;
    assign bus.running        = (state == ST_RUN);
    assign bus.fetch_count    = fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized redirect/stall
// traffic, checked every cycle against a cycle-level behavioural model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(8), .DATA_W(32)) bif ();

    fetch_stage #(.ADDR_W(8), .DATA_W(32), .RESET_PC(8'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    logic [31:0] mem [256];
    assign bif.instr_rd = mem[bif.pc];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: mode 0=idle 1=run 2=halted
    int          m_mode;
    int          m_pc;
    logic [31:0] m_instr;
    int          m_pp1;
    bit          m_valid;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = '0; m_pp1 = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int off;
        case (m_mode)
            0: if (bif.start && !bif.halt) m_mode = 1;
            1: begin
                if (bif.halt) begin
                    m_mode  = 2;
                    m_valid = 0;
                end else if (bif.branch_taken || bif.jump) begin
                    if (bif.branch_taken) begin
                        off  = int'($signed(bif.branch_offset));
                        m_pc = (m_pp1 + off) & 255;
                    end else begin
                        m_pc = int'(bif.jump_target) % 256;
                    end
                    m_instr = '0;
                    m_valid = 0;
                end else if (!bif.stall) begin
                    m_instr = mem[m_pc];
                    m_pp1   = (m_pc + 1) % 256;
                    m_pc    = (m_pc + 1) % 256;
                    m_valid = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("pc",       64'(bif.pc),             64'(m_pc));
        check("instr",    64'(bif.if_id_instr),    64'(m_instr));
        check("pc_plus1", 64'(bif.if_id_pc_plus1), 64'(m_pp1));
        check("valid",    64'(bif.if_id_valid),    64'(m_valid));
        check("running",  64'(bif.running),        64'(m_mode == 1));
        check("count",    64'(bif.fetch_count),    64'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        bif.start = 0; bif.halt = 0; bif.stall = 0; bif.branch_taken = 0;
        bif.branch_offset = '0; bif.jump = 0; bif.jump_target = '0;
    endtask

    initial begin
        logic [7:0] frozen_pc;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h20010003;
        mem[1] = 32'h20020009;
        clear_inputs();

        // 1: reset, then idle
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst_n = 1;
        repeat (5) step();
        check("t1_pc", 64'(bif.pc), 64'd0);
        check("t1_valid", 64'(bif.if_id_valid), 64'd0);
        check("t1_running", 64'(bif.running), 64'd0);
        check("t1_count", 64'(bif.fetch_count), 64'd0);

        // 2: start and first two fetches
        bif.start = 1;
        step();
        bif.start = 0;
        step();
        check("t2_instr0", 64'(bif.if_id_instr), 64'h20010003);
        check("t2_pp1_0", 64'(bif.if_id_pc_plus1), 64'd1);
        step();
        check("t2_instr1", 64'(bif.if_id_instr), 64'h20020009);
        check("t2_pp1_1", 64'(bif.if_id_pc_plus1), 64'd2);
        step();

        // 3: stall at pc=3
        check("t3_pc_pre", 64'(bif.pc), 64'd3);
        bif.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_pc_hold", 64'(bif.pc), 64'd3);
            check("t3_cnt_hold", 64'(bif.fetch_count), 64'd3);
            check("t3_pp1_hold", 64'(bif.if_id_pc_plus1), 64'd3);
        end
        bif.stall = 0;
        step();
        check("t3_pc_rel", 64'(bif.pc), 64'd4);
        step();

        // 4: backward branch from if_id_pc_plus1=5
        check("t4_pp1_pre", 64'(bif.if_id_pc_plus1), 64'd5);
        bif.branch_taken = 1;
        bif.branch_offset = 16'hFFFE;
        step();
        bif.branch_taken = 0;
        check("t4_pc", 64'(bif.pc), 64'd3);
        check("t4_valid", 64'(bif.if_id_valid), 64'd0);
        check("t4_instr", 64'(bif.if_id_instr), 64'd0);

        // 5: jump beats stall, then wrap 255 -> 0
        bif.jump = 1;
        bif.jump_target = 26'h0000006;
        bif.stall = 1;
        step();
        check("t5_jmp_pc", 64'(bif.pc), 64'd6);
        bif.stall = 0;
        bif.jump_target = 26'h3FFFFFF;
        step();
        bif.jump = 0;
        check("t5_pc255", 64'(bif.pc), 64'd255);
        step();
        check("t5_wrap_pc", 64'(bif.pc), 64'd0);
        check("t5_wrap_pp1", 64'(bif.if_id_pc_plus1), 64'd0);

        // Randomized redirect / stall traffic
        for (int i = 0; i < 1500; i++) begin
            bif.branch_taken  = ($urandom_range(0, 7) == 0);
            bif.jump          = ($urandom_range(0, 7) == 0);
            bif.stall         = ($urandom_range(0, 3) == 0);
            bif.branch_offset = 16'($urandom);
            bif.jump_target   = 26'($urandom);
            step();
        end
        clear_inputs();

        // 6b: asynchronous reset mid-RUN
        #2;
        rst_n = 0;
        #1;
        model_reset();
        compare_all();
        check("t6_rst_pc", 64'(bif.pc), 64'd0);
        check("t6_rst_running", 64'(bif.running), 64'd0);
        #2;
        rst_n = 1;
        step();
        check("t6_needs_start", 64'(bif.running), 64'd0);

        // Saturation of fetch_count
        bif.start = 1;
        step();
        bif.start = 0;
        for (int i = 0; i < 65540; i++) step();
        check("sat_count", 64'(bif.fetch_count), 64'hFFFF);

        // 6a: halt, with a simultaneous redirect, then start ignored
        frozen_pc = bif.pc;
        bif.halt = 1;
        bif.jump = 1;
        bif.jump_target = 26'h0000042;
        step();
        bif.halt = 0;
        bif.jump = 0;
        check("t6_halt_running", 64'(bif.running), 64'd0);
        check("t6_halt_pc", 64'(bif.pc), 64'(frozen_pc));
        bif.start = 1;
        step();
        step();
        bif.start = 0;
        check("t6_start_ign", 64'(bif.running), 64'd0);
        check("t6_pc_frozen", 64'(bif.pc), 64'(frozen_pc));
        check("t6_valid_off", 64'(bif.if_id_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
